// File: rtl/uc_pkg.sv
// ---------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the multicycle control unit:
//   - state_t     : state encodings driven on state_reg
//   - op_class_t  : instruction class produced by uc_decoder
//   - OP_*        : RV32I-subset major opcodes recognised by the unit
//   - ALU_*       : aluop encodings driven towards the datapath
// ---------------------------------------------------------------------------
package uc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH      = 4'd1,
        ST_DECODE     = 4'd2,
        ST_EXECUTE    = 4'd3,
        ST_WRITE_BACK = 4'd4,
        ST_MEM        = 4'd5,
        ST_TRAP       = 4'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } op_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    // Loads and stores both need a MEM phase after EXECUTE.
    function automatic logic is_mem_class(input op_class_t cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/multicycle_uc_if.sv
// ---------------------------------------------------------------------------
// multicycle_uc_if
// Memory request handshake between the control unit and instruction/data
// memory.
//   mem_req   : control unit requests a memory access (FETCH, MEM)
//   mem_write : qualifies the request as a store
//   mem_ready : memory completes the current request this cycle
// Modports: master = control unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface multicycle_uc_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_req, output mem_write, input mem_ready);
    modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/uc_decoder.sv
// ---------------------------------------------------------------------------
// uc_decoder
// Purely combinational opcode decode.
//   opcode_in : opcode to classify
//   op_class  : instruction class (CLS_NONE when unrecognised)
//   aluop     : ALU control for the EXECUTE phase of this class
//   legal     : opcode belongs to a supported class
// ---------------------------------------------------------------------------
module uc_decoder
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] opcode_in,
    output op_class_t           op_class,
    output logic [1:0]          aluop,
    output logic                legal
);

    always_comb begin
        op_class = CLS_NONE;
        aluop    = ALU_ADD;
        legal    = 1'b1;
        if (opcode_in == OPCODE_W'(OP_R)) begin
            op_class = CLS_R;
            aluop    = ALU_FUNCT;
        end else if (opcode_in == OPCODE_W'(OP_I)) begin
            op_class = CLS_I;
            aluop    = ALU_FUNCT;
        end else if (opcode_in == OPCODE_W'(OP_LOAD)) begin
            op_class = CLS_LOAD;
        end else if (opcode_in == OPCODE_W'(OP_STORE)) begin
            op_class = CLS_STORE;
        end else if (opcode_in == OPCODE_W'(OP_BRANCH)) begin
            op_class = CLS_BRANCH;
            aluop    = ALU_BRANCH;
        end else begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_uc.sv
// ---------------------------------------------------------------------------
// multicycle_uc
// Multicycle control unit: IDLE/FETCH/DECODE/EXECUTE/MEM/WRITE_BACK/TRAP.
//
// Parameters:
//   OPCODE_W    : opcode width
//   WB_CYCLES   : cycles spent in WRITE_BACK (1..8)
//   MEM_TIMEOUT : max memory wait cycles (only with UC_MEM_TIMEOUT_EN)
//
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   run          : keep executing instructions while high
//   opcode       : IR opcode field, sampled in DECODE
//   mem_bus      : memory handshake (mem_req / mem_write / mem_ready)
//   state_reg    : current state encoding
//   ir_load, pc_write : fetch completion strobes (gated by mem_ready)
//   branch, aluop     : EXECUTE controls
//   reg_write    : register-file write on the last WRITE_BACK cycle
//   illegal      : sticky illegal-opcode flag
//   timeout      : sticky memory-timeout flag
//
// Build option: define UC_MEM_TIMEOUT_EN to bound memory waits; without it
// waits are unbounded and timeout is constant 0.
// ---------------------------------------------------------------------------
module multicycle_uc
    import uc_pkg::*;
#(
    parameter int OPCODE_W    = 7,
    parameter int WB_CYCLES   = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    multicycle_uc_if.master     mem_bus,
    output logic [3:0]          state_reg,
    output logic                ir_load,
    output logic                pc_write,
    output logic                branch,
    output logic [1:0]          aluop,
    output logic                reg_write,
    output logic                illegal,
    output logic                timeout
);

    localparam int WB_W = (WB_CYCLES > 1) ? $clog2(WB_CYCLES) : 1;
    localparam logic [WB_W-1:0] WB_LAST = WB_W'(WB_CYCLES - 1);

    state_t              st_reg, st_next;
    logic [OPCODE_W-1:0] opcode_reg;
    logic [WB_W-1:0]     wb_cnt_reg;
    logic                illegal_reg;
    logic                illegal_set;
    logic                wait_expired;
    logic                mem_req_c, mem_write_c;
    state_t              eoi_state;

    op_class_t           dec_class;
    logic [1:0]          dec_aluop;
    logic                dec_legal;
    logic [OPCODE_W-1:0] dec_in;

    // In DECODE the legality check must see the live opcode (opcode_reg is
    // only being loaded this cycle); afterwards the latched copy is used so
    // EXECUTE/MEM controls depend on registered values only.
    assign dec_in = (st_reg == ST_DECODE) ? opcode : opcode_reg;

    uc_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
        .opcode_in (dec_in),
        .op_class  (dec_class),
        .aluop     (dec_aluop),
        .legal     (dec_legal)
    );

    // run is only looked at when an instruction finishes.
    assign eoi_state = run ? ST_FETCH : ST_IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_reg      <= ST_IDLE;
            opcode_reg  <= '0;
            wb_cnt_reg  <= '0;
            illegal_reg <= 1'b0;
        end else begin
            st_reg <= st_next;
            if (st_reg == ST_DECODE) begin
                opcode_reg <= opcode;
            end
            // Counter is zero whenever WRITE_BACK is entered.
            if (st_reg == ST_WRITE_BACK && st_next == ST_WRITE_BACK) begin
                wb_cnt_reg <= wb_cnt_reg + 1'b1;
            end else begin
                wb_cnt_reg <= '0;
            end
            if (illegal_set) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        st_next     = st_reg;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_load     = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        aluop       = ALU_ADD;
        reg_write   = 1'b0;
        illegal_set = 1'b0;
        case (st_reg)
            ST_IDLE: begin
                if (run) begin
                    st_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_bus.mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    st_next  = ST_DECODE;
                end else if (wait_expired) begin
                    st_next = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    st_next = ST_EXECUTE;
                end else begin
                    illegal_set = 1'b1;
                    st_next     = ST_TRAP;
                end
            end
            ST_EXECUTE: begin
                aluop = dec_aluop;
                if (dec_class == CLS_BRANCH) begin
                    branch  = 1'b1;
                    st_next = eoi_state;
                end else if (is_mem_class(dec_class)) begin
                    st_next = ST_MEM;
                end else if (dec_class == CLS_R || dec_class == CLS_I) begin
                    st_next = ST_WRITE_BACK;
                end else begin
                    // opcode_reg was checked legal in DECODE; unreachable.
                    st_next = ST_TRAP;
                end
            end
            ST_MEM: begin
                mem_req_c   = 1'b1;
                mem_write_c = (dec_class == CLS_STORE);
                if (mem_bus.mem_ready) begin
                    st_next = (dec_class == CLS_LOAD) ? ST_WRITE_BACK : eoi_state;
                end else if (wait_expired) begin
                    st_next = ST_TRAP;
                end
            end
            ST_WRITE_BACK: begin
                if (wb_cnt_reg == WB_LAST) begin
                    reg_write = 1'b1;
                    st_next   = eoi_state;
                end
            end
            ST_TRAP: begin
                st_next = ST_TRAP;
            end
            default: begin
                st_next = ST_IDLE;
            end
        endcase
    end

`ifdef UC_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timeout_reg;
    logic              in_wait;

    assign in_wait      = (st_reg == ST_FETCH || st_reg == ST_MEM) && !mem_bus.mem_ready;
    // Fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
    assign wait_expired = in_wait && (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            if (in_wait && st_next == st_reg) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            if (wait_expired) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign state_reg         = st_reg;
    assign illegal           = illegal_reg;
    assign mem_bus.mem_req   = mem_req_c;
    assign mem_bus.mem_write = mem_write_c;

endmodule

// File: doc/multicycle_uc.md
# multicycle_uc

Parametrised multicycle control unit sequencing IDLE/FETCH/DECODE/EXECUTE/MEM/WRITE_BACK for the RV32I-subset datapath. It sits between instruction/data memory and the register-file/ALU datapath. It adds a memory ready handshake, a configurable write-back length, a latched opcode decode that drives ALU and write controls, and trap on illegal opcodes. It replaces the fixed-sequence state machine and UC pair.

## Interface
- OPCODE_W, 7, opcode width
- WB_CYCLES, 1, cycles spent in WRITE_BACK (1..8)
- MEM_TIMEOUT, 15, max wait cycles for mem_ready (used only with macro)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; high = execute instructions continuously
- opcode  in  OPCODE_W  opcode field from IR, valid in DECODE
- mem_ready  in  1  memory completes current request
- state_reg  out  4  current state encoding
- mem_req  out  1  memory request (FETCH, MEM)
- mem_write  out  1  store request qualifier (MEM, store only)
- ir_load  out  1  load IR (FETCH and mem_ready)
- pc_write  out  1  PC+4 update (FETCH and mem_ready)
- branch  out  1  branch evaluate strobe (EXECUTE, branch only)
- aluop  out  2  00 add, 01 branch compare, 10 funct-decoded
- reg_write  out  1  register-file write (last WRITE_BACK cycle)
- illegal  out  1  sticky illegal-opcode flag
- timeout  out  1  sticky memory-timeout flag (0 without macro)

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITE_BACK=4, MEM=5, TRAP=6; other codes go to IDLE.
- IDLE: goes to FETCH when run=1; otherwise stays.
- FETCH: mem_req=1 and waits for mem_ready. On the mem_ready cycle, ir_load=1 and pc_write=1, then DECODE.
- DECODE: latches opcode into opcode_q. Classes: 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch. Any other opcode: illegal set, go to TRAP.
- EXECUTE: aluop is 10 for R/I, 00 for load/store, 01 for branch. branch=1 for branch. Next state is MEM for load/store, WRITE_BACK for R/I, and end-of-instruction for branch.
- MEM: mem_req=1, mem_write=1 for store, waits for mem_ready. Load goes to WRITE_BACK; store goes to end-of-instruction.
- WRITE_BACK: wb_cnt counts 0..WB_CYCLES-1. reg_write=1 only when wb_cnt==WB_CYCLES-1, then end-of-instruction. wb_cnt clears on entry.
- End-of-instruction: go to FETCH if run=1, else IDLE. Dropping run mid-instruction always lets the current instruction finish.
- TRAP: all strobes 0. The block exits only via reset_n.
- Outputs are decoded from registered state_reg and opcode_q only. They do not depend on opcode or mem_ready combinationally, except ir_load, pc_write and the FETCH/MEM exit qualifiers, which are gated by mem_ready.
- mem_ready is ignored outside FETCH and MEM.

## Timing
- Async reset: state_reg=IDLE, opcode_q=0, counters=0, all outputs 0, illegal=0, timeout=0.
- Reset asserted mid-instruction aborts the instruction immediately; no further strobes.
- Zero-wait R-type: FETCH, DECODE, EXECUTE, then WB_CYCLES cycles of WRITE_BACK. Total 3+WB_CYCLES cycles. Load adds 1+wait cycles for MEM. Store: 4 cycles. Branch: 3 cycles.
- Each memory wait cycle extends FETCH or MEM by one cycle. mem_req holds high through the wait.
- run sampled at IDLE and end-of-instruction only.

## Configuration
- UC_MEM_TIMEOUT_EN defined: a wait counter runs in FETCH/MEM and clears on state entry. If it reaches MEM_TIMEOUT without mem_ready, timeout is set (sticky) and the next state is TRAP.
- UC_MEM_TIMEOUT_EN undefined: waits are unbounded, no counter is built, and timeout is tied to 0.

## Structure
- Package uc_pkg holds the state encodings, opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH) and aluop constants.
- Sub-module uc_decoder is combinational: opcode_q to class, aluop and legal. It is instantiated once.

## Test plan
- run=1, opcode=0110011, mem_ready=1, WB_CYCLES=1 -> states 1,2,3,4,1. aluop=10 in EXECUTE. reg_write is high one cycle in WRITE_BACK.
- Load 0000011, mem_ready low 3 cycles in MEM -> mem_req high 4 cycles in MEM. WRITE_BACK follows with reg_write=1.
- Store 0100011 -> MEM with mem_req=mem_write=1, then FETCH. reg_write never asserted.
- opcode=1111111 -> TRAP after DECODE, illegal=1, all strobes stay 0 until reset_n low.
- run dropped during EXECUTE of R-type -> WRITE_BACK completes, then IDLE. reset_n pulse mid-FETCH -> IDLE next edge, outputs 0.
- With UC_MEM_TIMEOUT_EN, MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> after 15 wait cycles, timeout=1 and state TRAP.
